// File: rtl/cpu_cpu_mul_seq.sv
// cpu_cpu_mul_seq -- sequential 32x32 multiplier built on one 16x16 unsigned
// multiplier. It returns the low word (MUL) or the high word (MULXUU/MULXSS/
// MULXSU). The four partial products go into a 64-bit accumulator. The signed
// high word comes from the unsigned product with a final correction step.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready request handshake; req_op, req_src1, req_src2 operands
//   flush               abandon any operation in flight (forces IDLE)
//   rsp_valid/rsp_ready response handshake; rsp_result result word
//   busy                high whenever the FSM is not in IDLE
//
// Timing from the acceptance edge:
//   MUL : ISSUE k0,k1,k2 -> DRAIN -> DONE             (rsp_valid after 4 edges)
//   MULX: ISSUE k0..k3   -> DRAIN -> CORR -> DONE     (rsp_valid after 6 edges)
module cpu_cpu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    CORR  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  state_t      state;
  logic [1:0]  k;        // partial-product index while in ISSUE
  logic [31:0] a, b;     // latched operands; they feed the multiplier mux
  logic [1:0]  op;
  logic [63:0] acc;
  logic [31:0] p;        // registered multiplier product
  logic        p_vld;    // p holds a product still to be accumulated
  logic [1:0]  p_k;      // index of the product in p; sets its shift

  logic [15:0] mul_a, mul_b;
  logic [63:0] p_shifted, acc_nxt;
  logic [31:0] hi_corr;
  logic        is_mul, a_sgn;

  assign is_mul    = (op == OP_MUL);
  assign a_sgn     = (op == OP_MULXSS) || (op == OP_MULXSU);
  assign req_ready = (state == IDLE) && !flush && !reset;
  assign busy      = (state != IDLE);

  // k[0] selects the A half and k[1] selects the B half:
  // k0 = Alo*Blo, k1 = Ahi*Blo, k2 = Alo*Bhi, k3 = Ahi*Bhi.
  always_comb begin
    mul_a = k[0] ? a[31:16] : a[15:0];
    mul_b = k[1] ? b[31:16] : b[15:0];
  end

  always_comb begin
    p_shifted = 64'd0;
    case (p_k)
      2'd0:    p_shifted = {32'd0, p};
      2'd1,
      2'd2:    p_shifted = {16'd0, p, 16'd0};
      default: p_shifted = {p, 32'd0};
    endcase
  end

  assign acc_nxt = p_vld ? (acc + p_shifted) : acc;

  // Signed high word from the unsigned product. A negative signed operand X
  // gives an unsigned product that is too large by (other operand) << 32.
  assign hi_corr = acc[63:32]
                 - ((a_sgn && a[31])             ? b : 32'd0)
                 - ((op == OP_MULXSS && b[31])   ? a : 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      k          <= 2'd0;
      acc        <= 64'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
      p_vld      <= 1'b0;
      p_k        <= 2'd0;
      p          <= 32'd0;
      a          <= 32'd0;
      b          <= 32'd0;
      op         <= OP_MUL;
    end else begin
      acc   <= acc_nxt;
      p_vld <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        k         <= 2'd0;
        rsp_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              a     <= req_src1;
              b     <= req_src2;
              op    <= req_op;
              acc   <= 64'd0;
              k     <= 2'd0;
              state <= ISSUE;
            end
          end
          ISSUE: begin
            p     <= {16'd0, mul_a} * {16'd0, mul_b};
            p_vld <= 1'b1;
            p_k   <= k;
            // MUL never needs Ahi*Bhi because it only affects bits 63:32.
            if ((is_mul && k == 2'd2) || k == 2'd3) begin
              k     <= 2'd0;
              state <= DRAIN;
            end else begin
              k <= k + 2'd1;
            end
          end
          DRAIN: begin
            // The last product is added on this edge, so use acc_nxt here.
            if (is_mul) begin
              rsp_result <= acc_nxt[31:0];
              rsp_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= CORR;
            end
          end
          CORR: begin
            rsp_result <= hi_corr;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
          DONE: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_cpu_mul_seq.sv
module tb_cpu_cpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, flush, rsp_valid, rsp_ready, busy;
  logic [1:0]  req_op;
  logic [31:0] req_src1, req_src2, rsp_result;

  cpu_cpu_mul_seq dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  logic        prev_vld = 1'b0;
  logic [31:0] prev_res = 32'd0;
  exp_t        e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: inputs change just after posedge, so at negedge they show what
  // the next posedge will sample.
  always @(negedge clk) begin
    if (req_valid && req_ready) acc_cyc <= cyc + 1;
    if (rsp_valid) begin
      if (!prev_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", rsp_result, e.res);
          chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
        end
      end else begin
        chk("result_hold", rsp_result, prev_res);
      end
      chk("req_ready_in_done", 32'(req_ready), 32'd0);
    end
    prev_vld <= rsp_valid;
    prev_res <= rsp_result;
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input bit expect_rsp, output int acc_at);
    int n;
    if (expect_rsp) sb.push_back('{res, (op == 2'b00) ? 4 : 6});
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    acc_at = cyc;
    // Scramble the inputs while busy. The operation in flight must not change.
    req_valid = 1'b0; req_op = 2'($urandom); req_src1 = $urandom; req_src2 = $urandom;
  endtask

  // Issue one operation. Then check that the next request can be presented
  // 5 (MUL) or 7 (MULX) cycles after acceptance; it is taken on the next edge.
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res);
    int acc_at, n;
    issue(op, a, b, res, 1'b1, acc_at);
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_gap", 32'(cyc - acc_at), (op == 2'b00) ? 32'd5 : 32'd7);
  endtask

  initial begin
    int acc_at, n;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_src1 = 32'd0; req_src2 = 32'd0;
    flush = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    reset = 1'b0; #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Back-to-back directed vectors with rsp_ready held high.
    run(2'b00, 32'h00010003, 32'h00020005, 32'h000B000F);
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(2'b10, 32'h80000000, 32'h80000000, 32'h40000000);
    run(2'b11, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run(2'b01, 32'h80000000, 32'h00000004, 32'h00000002);
    run(2'b10, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
    run(2'b00, 32'hFFFF0000, 32'h00010000, 32'h00000000);

    // Backpressure: hold rsp_ready low for 3 cycles once the result is up.
    rsp_ready = 1'b0;
    issue(2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 1'b1, acc_at);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    repeat (3) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
    chk("bp_idle_ready", 32'(req_ready), 32'd1);

    // Flush 2 cycles after acceptance; no response may follow.
    issue(2'b01, 32'hDEADBEEF, 32'h12345678, 32'd0, 1'b0, acc_at);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; #1;
    chk("flush_ready", 32'(req_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    run(2'b00, 32'd3, 32'd5, 32'h0000000F);

    // Reset 3 cycles into a MULXSS; no response may follow.
    issue(2'b10, 32'h00000007, 32'h00000009, 32'd0, 1'b0, acc_at);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    chk("mid_rst_ready_rel", 32'(req_ready), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    run(2'b11, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
    run(2'b00, 32'd3, 32'd5, 32'h0000000F);

    repeat (10) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
